// File: rtl/joystick_axis_scanner.sv
// Round-robin XADC aux-channel poller over DRP: averages 2^AVG_LOG2 reads per
// channel and derives hysteretic low/high direction flags plus rising-edge pulses.
module joystick_axis_scanner #(
  parameter int         NUM_CH      = 2,
  parameter int         DATA_W      = 12,
  parameter logic [6:0] BASE_ADDR   = 7'h16,
  parameter int         AVG_LOG2    = 2,
  parameter int         THRESH_LOW  = 1000,
  parameter int         THRESH_HIGH = 3000,
  parameter int         HYST        = 100,
  parameter int         TIMEOUT     = 255
) (
  input  logic                     clk_100MHz,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     err_clear,
  output logic [6:0]               drp_daddr,
  output logic                     drp_den,
  input  logic                     drp_drdy,
  input  logic [15:0]              drp_do,
  output logic [NUM_CH*DATA_W-1:0] axis_data,
  output logic                     sample_valid,
  output logic [NUM_CH-1:0]        dir_low,
  output logic [NUM_CH-1:0]        dir_high,
  output logic [NUM_CH-1:0]        dir_low_pulse,
  output logic [NUM_CH-1:0]        dir_high_pulse,
  output logic                     timeout_err
);

  localparam int          CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          RND_W  = AVG_LOG2 + 1;
  localparam int          ACC_W  = DATA_W + AVG_LOG2;
  localparam int          CNT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned ROUNDS = 1 << AVG_LOG2;

  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [RND_W-1:0] RND_LAST  = RND_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]      LOW_SET   = 32'(THRESH_LOW);
  localparam logic [31:0]      LOW_CLR   = 32'(THRESH_LOW + HYST);
  localparam logic [31:0]      HIGH_SET  = 32'(THRESH_HIGH);
  localparam logic [31:0]      HIGH_CLR  = 32'(THRESH_HIGH - HYST);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, UPDATE} state_t;

  state_t                     state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [RND_W-1:0]           round_q, round_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ACC_W-1:0]           acc_q [NUM_CH];
  logic [ACC_W-1:0]           acc_d [NUM_CH];
  logic [6:0]                 daddr_q, daddr_d;
  logic [NUM_CH*DATA_W-1:0]   axis_q, axis_d;
  logic                       sv_q, sv_d;
  logic [NUM_CH-1:0]          low_q, low_d, high_q, high_d;
  logic [NUM_CH-1:0]          low_pulse_q, low_pulse_d, high_pulse_q, high_pulse_d;
  logic                       err_q, err_d;

  logic                       timeout_hit;
  logic                       rd_done;
  logic [DATA_W-1:0]          rd_val;
  logic [31:0]                avg_v;

  // A read that times out contributes the channel's last published value,
  // so every average still divides by the full number of rounds.
  assign timeout_hit = (state_q == WAIT) && !drp_drdy && (cnt_q == CNT_LAST);
  assign rd_done     = (state_q == WAIT) && (drp_drdy || timeout_hit);
  assign rd_val      = drp_drdy ? drp_do[15 -: DATA_W] : axis_q[int'(ch_q) * DATA_W +: DATA_W];

  generate
    if (DATA_W < 16) begin : g_unused
      logic unused_lsbs;
      assign unused_lsbs = ^drp_do[15-DATA_W:0];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    round_d      = round_q;
    cnt_d        = cnt_q;
    daddr_d      = daddr_q;
    acc_d        = acc_q;
    axis_d       = axis_q;
    sv_d         = 1'b0;
    low_d        = low_q;
    high_d       = high_q;
    low_pulse_d  = '0;
    high_pulse_d = '0;
    avg_v        = '0;
    err_d        = timeout_hit ? 1'b1 : (err_clear ? 1'b0 : err_q);

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ISSUE;
          ch_d    = '0;
          round_d = '0;
          daddr_d = BASE_ADDR;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!rd_done) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          acc_d[ch_q] = acc_q[ch_q] + ACC_W'(rd_val);
          if (!enable) begin
            state_d = IDLE;
            ch_d    = '0;
            round_d = '0;
            for (int k = 0; k < NUM_CH; k++) acc_d[k] = '0;
          end else if (ch_q != CH_LAST) begin
            ch_d    = ch_q + 1'b1;
            daddr_d = BASE_ADDR + 7'(ch_q) + 7'd1;
            state_d = ISSUE;
          end else if (round_q != RND_LAST) begin
            ch_d    = '0;
            round_d = round_q + 1'b1;
            daddr_d = BASE_ADDR;
            state_d = ISSUE;
          end else begin
            // Results are registered here so they appear during the UPDATE cycle.
            ch_d    = '0;
            round_d = '0;
            state_d = UPDATE;
            sv_d    = 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
              avg_v = 32'(acc_d[k] >> AVG_LOG2);
              axis_d[k*DATA_W +: DATA_W] = avg_v[DATA_W-1:0];
              if (avg_v < LOW_SET)        low_d[k] = 1'b1;
              else if (avg_v >= LOW_CLR)  low_d[k] = 1'b0;
              if (avg_v > HIGH_SET)       high_d[k] = 1'b1;
              else if (avg_v <= HIGH_CLR) high_d[k] = 1'b0;
              low_pulse_d[k]  = low_d[k] & ~low_q[k];
              high_pulse_d[k] = high_d[k] & ~high_q[k];
              acc_d[k] = '0;
            end
          end
        end
      end
      UPDATE: begin
        if (enable) begin
          state_d = ISSUE;
          daddr_d = BASE_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      round_q      <= '0;
      cnt_q        <= '0;
      daddr_q      <= '0;
      axis_q       <= '0;
      sv_q         <= 1'b0;
      low_q        <= '0;
      high_q       <= '0;
      low_pulse_q  <= '0;
      high_pulse_q <= '0;
      err_q        <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      round_q      <= round_d;
      cnt_q        <= cnt_d;
      daddr_q      <= daddr_d;
      axis_q       <= axis_d;
      sv_q         <= sv_d;
      low_q        <= low_d;
      high_q       <= high_d;
      low_pulse_q  <= low_pulse_d;
      high_pulse_q <= high_pulse_d;
      err_q        <= err_d;
      acc_q        <= acc_d;
    end
  end

  assign drp_den        = (state_q == ISSUE);
  assign drp_daddr      = daddr_q;
  assign axis_data      = axis_q;
  assign sample_valid   = sv_q;
  assign dir_low        = low_q;
  assign dir_high       = high_q;
  assign dir_low_pulse  = low_pulse_q;
  assign dir_high_pulse = high_pulse_q;
  assign timeout_err    = err_q;

endmodule

// File: tb/tb_joystick_axis_scanner.sv
// Directed bench: a DRP responder feeds scripted samples, a behavioural model of
// averaging and hysteresis is compared every cycle, plus hand-computed literals.
module tb_joystick_axis_scanner;

  logic        clk = 1'b0;
  logic        rst_n, enable, err_clear, drp_drdy, drp_den, sample_valid, timeout_err;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_do;
  logic [23:0] axis_data;
  logic [1:0]  dir_low, dir_high, dir_low_pulse, dir_high_pulse;

  joystick_axis_scanner #(
    .NUM_CH(2), .DATA_W(12), .BASE_ADDR(7'h16), .AVG_LOG2(2),
    .THRESH_LOW(1000), .THRESH_HIGH(3000), .HYST(100), .TIMEOUT(255)
  ) dut (
    .clk_100MHz(clk), .rst_n(rst_n), .enable(enable), .err_clear(err_clear),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_drdy(drp_drdy), .drp_do(drp_do),
    .axis_data(axis_data), .sample_valid(sample_valid),
    .dir_low(dir_low), .dir_high(dir_high),
    .dir_low_pulse(dir_low_pulse), .dir_high_pulse(dir_high_pulse),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] vq0[$];
  logic [11:0] vq1[$];
  logic [6:0]  addr_log[$];
  bit          stall1 = 1'b0;

  int          mdl_sum [2];
  int          mdl_n   [2];
  logic [11:0] mdl_axis[2];
  bit          mdl_low [2];
  bit          mdl_high[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // DRP slave: answers one cycle after den; a stalled ch1 read never answers.
  initial begin : responder
    int          ch;
    logic [11:0] v;
    drp_drdy = 1'b0;
    drp_do   = 16'h0;
    forever begin
      @(negedge clk);
      if (rst_n && drp_den) begin
        ch = int'(drp_daddr) - 'h16;
        addr_log.push_back(drp_daddr);
        if (ch == 1 && stall1) begin
          stall1 = 1'b0;
          mdl_sum[1] += int'(mdl_axis[1]);
          mdl_n[1]++;
        end else begin
          v = 12'h800;
          if (ch == 0 && vq0.size() > 0) v = vq0.pop_front();
          else if (ch == 1 && vq1.size() > 0) v = vq1.pop_front();
          @(posedge clk);
          #1;
          drp_drdy = 1'b1;
          drp_do   = {v, 4'h0};
          if (ch >= 0 && ch < 2) begin
            mdl_sum[ch] += int'(v);
            mdl_n[ch]++;
          end
          @(posedge clk);
          #1;
          drp_drdy = 1'b0;
          drp_do   = 16'h0;
        end
      end
    end
  end

  // Model: average = floor(sum/4); hysteresis thresholds 1000/1100 and 3000/2900.
  initial begin : compare
    int          ev;
    bit          nl, nh;
    logic [11:0] got;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          mdl_sum[k] = 0; mdl_n[k] = 0; mdl_axis[k] = '0;
          mdl_low[k] = 1'b0; mdl_high[k] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          got = axis_data[k*12 +: 12];
          if (sample_valid) begin
            ev = mdl_sum[k] / 4;
            nl = (ev < 1000) ? 1'b1 : ((ev >= 1100) ? 1'b0 : mdl_low[k]);
            nh = (ev > 3000) ? 1'b1 : ((ev <= 2900) ? 1'b0 : mdl_high[k]);
            chk($sformatf("reads_per_update%0d", k), mdl_n[k], 4);
            chk($sformatf("axis%0d", k), got, ev);
            chk($sformatf("dir_low%0d", k), dir_low[k], nl);
            chk($sformatf("dir_high%0d", k), dir_high[k], nh);
            chk($sformatf("low_pulse%0d", k), dir_low_pulse[k], nl & !mdl_low[k]);
            chk($sformatf("high_pulse%0d", k), dir_high_pulse[k], nh & !mdl_high[k]);
            mdl_axis[k] = 12'(ev);
            mdl_low[k]  = nl;
            mdl_high[k] = nh;
            mdl_sum[k]  = 0;
            mdl_n[k]    = 0;
          end else begin
            chk($sformatf("axis_hold%0d", k), got, mdl_axis[k]);
            chk($sformatf("low_hold%0d", k), dir_low[k], mdl_low[k]);
            chk($sformatf("high_hold%0d", k), dir_high[k], mdl_high[k]);
            chk($sformatf("pulse_idle%0d", k), {dir_low_pulse[k], dir_high_pulse[k]}, 0);
          end
          chk($sformatf("exclusive%0d", k), dir_low[k] & dir_high[k], 0);
        end
      end
    end
  end

  task automatic wait_sv(input int limit, output int at);
    bit got = 1'b0;
    at = -1;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (sample_valid) begin got = 1'b1; at = cyc; end
    end
    chk("sample_valid_seen", got, 1);
  endtask

  task automatic wait_den(input bit any, input logic [6:0] addr, input int limit, output int at);
    bit got = 1'b0;
    at = -1;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (drp_den && (any || drp_daddr == addr)) begin got = 1'b1; at = cyc; end
    end
    chk("den_seen", got, 1);
  endtask

  task automatic push4(input logic [11:0] a0, a1, a2, a3, input bit to_ch1);
    if (to_ch1) begin vq1.push_back(a0); vq1.push_back(a1); vq1.push_back(a2); vq1.push_back(a3); end
    else        begin vq0.push_back(a0); vq0.push_back(a1); vq0.push_back(a2); vq0.push_back(a3); end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t0, t1, n_sv, n_den;
    rst_n = 1'b0; enable = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_den", drp_den, 0);
    chk("rst_daddr", drp_daddr, 0);
    chk("rst_axis", axis_data, 0);
    chk("rst_flags", {sample_valid, dir_low, dir_high, dir_low_pulse, dir_high_pulse, timeout_err}, 0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_den", drp_den, 0);

    // Whole scripted sequence of reads, in per-channel order.
    push4(12'h800, 12'h800, 12'h800, 12'h800, 0); push4(12'h800, 12'h800, 12'h800, 12'h800, 1);
    push4(3200, 3200, 3200, 3200, 0);             push4(2000, 2000, 2000, 2000, 1);
    push4(2950, 2950, 2950, 2950, 0);             push4(1000, 1000, 1000, 1000, 1);
    push4(2900, 2900, 2900, 2900, 0);             push4(999, 999, 999, 999, 1);
    push4(1000, 1001, 1002, 1005, 0);             push4(1099, 1099, 1099, 1099, 1);
    push4(3000, 3000, 3000, 3000, 0);             push4(1100, 1100, 1100, 1100, 1);
    push4(500, 500, 500, 500, 0);
    vq1.push_back(2000); vq1.push_back(2000); vq1.push_back(2000);
    push4(500, 500, 500, 500, 0);
    vq1.push_back(2000); vq1.push_back(2000); vq1.push_back(2000);

    addr_log.delete();
    enable = 1'b1;
    wait_den(1'b1, 7'h0, 10, t0);
    wait_sv(40, t1);
    chk("latency", t1 - t0, 16);
    chk("addr_count", addr_log.size(), 8);
    for (int i = 0; i < 8 && i < addr_log.size(); i++)
      chk($sformatf("addr%0d", i), addr_log[i], 7'h16 + 7'(i % 2));
    chk("mid_axis", axis_data, 24'h800800);
    chk("mid_flags", {dir_low, dir_high}, 0);

    wait_sv(40, t1);
    chk("high_axis0", axis_data[11:0], 3200);
    chk("high_set", dir_high, 2'b01);
    chk("high_pulse", dir_high_pulse, 2'b01);
    @(negedge clk);
    chk("high_pulse_one_cycle", dir_high_pulse, 2'b00);

    wait_sv(40, t1);
    chk("high_hold", dir_high, 2'b01);
    chk("high_hold_nopulse", dir_high_pulse, 2'b00);
    chk("low_boundary_axis1", axis_data[23:12], 1000);
    chk("low_boundary", dir_low, 2'b00);

    wait_sv(40, t1);
    chk("high_clear", dir_high, 2'b00);
    chk("low_set", dir_low, 2'b10);
    chk("low_pulse", dir_low_pulse, 2'b10);

    wait_sv(40, t1);
    chk("trunc_axis0", axis_data[11:0], 1002);
    chk("low_hold", dir_low, 2'b10);
    chk("low_hold_nopulse", dir_low_pulse, 2'b00);

    wait_sv(40, t1);
    chk("high_boundary", dir_high, 2'b00);
    chk("low_clear", dir_low, 2'b00);
    stall1 = 1'b1;

    wait_den(1'b0, 7'h17, 20, t0);
    repeat (255) @(posedge clk);
    #1 chk("timeout_not_early", timeout_err, 0);
    @(posedge clk);
    #1 chk("timeout_set", timeout_err, 1);
    wait_sv(600, t1);
    chk("timeout_axis1", axis_data[23:12], 1775);
    chk("timeout_low0", dir_low, 2'b01);
    chk("timeout_low_pulse", dir_low_pulse, 2'b01);

    err_clear = 1'b1;
    stall1    = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    chk("err_clear", timeout_err, 0);

    wait_den(1'b0, 7'h17, 20, t0);
    repeat (255) @(posedge clk);
    #1 err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    chk("err_set_wins", timeout_err, 1);
    wait_sv(600, t1);

    wait_den(1'b1, 7'h0, 10, t0);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2; k++) begin mdl_sum[k] = 0; mdl_n[k] = 0; end
    vq0.delete(); vq1.delete();
    n_sv = 0; n_den = 0;
    repeat (40) begin
      @(negedge clk);
      if (sample_valid) n_sv++;
      if (drp_den) n_den++;
    end
    chk("disabled_no_sv", n_sv, 0);
    chk("disabled_no_den", n_den, 0);

    push4(2000, 2000, 2000, 2000, 0); push4(2000, 2000, 2000, 2000, 1);
    enable = 1'b1;
    wait_den(1'b1, 7'h0, 10, t0);
    chk("restart_addr", drp_daddr, 7'h16);
    wait_sv(40, t1);
    chk("restart_latency", t1 - t0, 16);
    chk("restart_axis", axis_data, 24'h7D07D0);
    chk("restart_low", dir_low, 2'b00);

    wait_den(1'b1, 7'h0, 10, t0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_den", drp_den, 0);
    chk("arst_daddr", drp_daddr, 0);
    chk("arst_axis", axis_data, 0);
    chk("arst_flags", {sample_valid, dir_low, dir_high, dir_low_pulse, dir_high_pulse, timeout_err}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
